// File: rtl/register_fifo_pkg.sv
// rtl/register_fifo_pkg.sv - shared defaults and width helper for register_fifo
//
// Purpose: default WIDTH/DEPTH/AF_LEVEL and a ceil-log2 function used to size
//          the read/write pointers and the occupancy count.
// Ports  : none (package).

package register_fifo_pkg;

   localparam int DEF_WIDTH    = 6;
   localparam int DEF_DEPTH    = 8;
   localparam int DEF_AF_LEVEL = 6;

   function automatic int clog2(input int value);
      int result;
      result = 0;
      while ((1 << result) < value) begin
         result = result + 1;
      end
      return result;
   endfunction

endpackage

// File: rtl/register_fifo_register_nbit.sv
// rtl/register_fifo_register_nbit.sv - WIDTH-bit enable register cell
//
// Purpose: one storage entry; loads in when wE is high at the rising edge.
// Ports  : clk   - rising-edge clock
//          reset - asynchronous active-low reset, clears the entry
//          wE    - load enable
//          in    - data to load
//          out   - stored value

module register_nbit #(
   parameter int WIDTH = 6
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             wE,
   input  logic [WIDTH-1:0] in,
   output logic [WIDTH-1:0] out
);

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         out <= '0;
      end else if (wE) begin
         out <= in;
      end
   end

endmodule

// File: rtl/register_fifo.sv
// rtl/register_fifo.sv - DEPTH x WIDTH register FIFO with status and sticky errors
//
// Purpose: first-in/first-out bank of enable registers with show-ahead output,
//          occupancy count, full/empty/almost-full status and sticky
//          overflow/underflow flags cleared by clr_err.
// Ports  : clk         - rising-edge clock
//          reset       - asynchronous active-low reset
//          wE / in     - push request and data
//          rE          - pop request
//          clr_err     - synchronous clear of overflow/underflow
//          out         - head entry, 0 while empty
//          empty, full, almost_full - decoded from the registered count
//          count       - current occupancy
//          overflow    - push while full without a pop
//          underflow   - pop while empty

module register_fifo
   import register_fifo_pkg::*;
#(
   parameter int WIDTH    = DEF_WIDTH,
   parameter int DEPTH    = DEF_DEPTH,
   parameter int AF_LEVEL = DEF_AF_LEVEL
) (
   input  logic                    clk,
   input  logic                    reset,
   input  logic                    wE,
   input  logic [WIDTH-1:0]        in,
   input  logic                    rE,
   input  logic                    clr_err,
   output logic [WIDTH-1:0]        out,
   output logic                    empty,
   output logic                    full,
   output logic                    almost_full,
   output logic [clog2(DEPTH):0]   count,
   output logic                    overflow,
   output logic                    underflow
);

   localparam int PTR_W = clog2(DEPTH);
   localparam int CNT_W = PTR_W + 1;

   logic [PTR_W-1:0] r_wr_ptr;
   logic [PTR_W-1:0] r_rd_ptr;
   logic [CNT_W-1:0] r_count;
   logic             r_overflow;
   logic             r_underflow;

   logic             w_push;
   logic             w_pop;
   logic [WIDTH-1:0] w_entry [DEPTH];

   assign empty       = (r_count == '0);
   assign full        = (r_count == CNT_W'(DEPTH));
   assign almost_full = (r_count >= CNT_W'(AF_LEVEL));
   assign count       = r_count;
   assign overflow    = r_overflow;
   assign underflow   = r_underflow;

   // A pop frees the slot in the same edge, so a full FIFO may still accept a push.
   assign w_push = wE & (~full | rE);
   assign w_pop  = rE & ~empty;

   assign out = empty ? '0 : w_entry[r_rd_ptr];

   for (genvar i = 0; i < DEPTH; i++) begin : g_entry
      register_nbit #(.WIDTH(WIDTH)) u_cell (
         .clk   (clk),
         .reset (reset),
         .wE    (w_push & (r_wr_ptr == PTR_W'(i))),
         .in    (in),
         .out   (w_entry[i])
      );
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_wr_ptr    <= '0;
         r_rd_ptr    <= '0;
         r_count     <= '0;
         r_overflow  <= 1'b0;
         r_underflow <= 1'b0;
      end else begin
         if (w_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
         if (w_pop)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);

         case ({w_push, w_pop})
            2'b10:   r_count <= r_count + CNT_W'(1);
            2'b01:   r_count <= r_count - CNT_W'(1);
            default: r_count <= r_count;
         endcase

         // A new error on the same edge as clr_err keeps the flag set.
         if (wE & full & ~rE)  r_overflow <= 1'b1;
         else if (clr_err)     r_overflow <= 1'b0;

         if (rE & empty)       r_underflow <= 1'b1;
         else if (clr_err)     r_underflow <= 1'b0;
      end
   end

endmodule

// File: tb/tb_register_fifo.sv
// tb/tb_register_fifo.sv - directed self-checking bench for register_fifo

module tb_register_fifo;

   logic       clk;
   logic       reset;
   logic       wE;
   logic [5:0] din;
   logic       rE;
   logic       clr_err;
   logic [5:0] dout;
   logic       empty;
   logic       full;
   logic       almost_full;
   logic [3:0] count;
   logic       overflow;
   logic       underflow;

   int n_vec;
   int n_err;

   register_fifo #(.WIDTH(6), .DEPTH(8), .AF_LEVEL(6)) dut (
      .clk         (clk),
      .reset       (reset),
      .wE          (wE),
      .in          (din),
      .rE          (rE),
      .clr_err     (clr_err),
      .out         (dout),
      .empty       (empty),
      .full        (full),
      .almost_full (almost_full),
      .count       (count),
      .overflow    (overflow),
      .underflow   (underflow)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic push(input logic [5:0] d);
      wE  = 1'b1;
      din = d;
      step();
      wE  = 1'b0;
   endtask

   task automatic pop_chk(input string tag, input logic [5:0] exp);
      chk(tag, 32'(dout), 32'(exp));
      rE = 1'b1;
      step();
      rE = 1'b0;
   endtask

   initial begin
      logic [5:0] d;
      n_vec   = 0;
      n_err   = 0;
      reset   = 1'b0;
      wE      = 1'b0;
      rE      = 1'b0;
      clr_err = 1'b0;
      din     = '0;

      // Reset state
      step();
      step();
      chk("rst_empty", 32'(empty), 32'd1);
      chk("rst_full", 32'(full), 32'd0);
      chk("rst_af", 32'(almost_full), 32'd0);
      chk("rst_out", 32'(dout), 32'd0);
      chk("rst_count", 32'(count), 32'd0);
      chk("rst_ovf", 32'(overflow), 32'd0);
      chk("rst_udf", 32'(underflow), 32'd0);
      reset = 1'b1;
      step();

      // Reset mid-fill acts without a clock edge
      push(6'h01);
      push(6'h02);
      push(6'h03);
      chk("fill3_count", 32'(count), 32'd3);
      #2 reset = 1'b0;
      #1;
      chk("async_count", 32'(count), 32'd0);
      chk("async_empty", 32'(empty), 32'd1);
      chk("async_out", 32'(dout), 32'd0);
      #1 reset = 1'b1;
      step();
      push(6'h15);
      chk("post_rst_out", 32'(dout), 32'h15);
      chk("post_rst_count", 32'(count), 32'd1);
      pop_chk("post_rst_pop", 6'h15);
      chk("post_rst_empty", 32'(empty), 32'd1);

      // Fill to full
      for (int i = 1; i <= 8; i++) begin
         push(6'(i));
         chk("fill_count", 32'(count), 32'(i));
         chk("fill_af", 32'(almost_full), (i >= 6) ? 32'd1 : 32'd0);
         chk("fill_full", 32'(full), (i == 8) ? 32'd1 : 32'd0);
      end
      push(6'h3F);
      chk("ovf_set", 32'(overflow), 32'd1);
      chk("ovf_count", 32'(count), 32'd8);
      chk("ovf_head", 32'(dout), 32'h01);

      // Error clear, then clear racing a new overflow
      clr_err = 1'b1;
      step();
      clr_err = 1'b0;
      chk("clr_ovf", 32'(overflow), 32'd0);
      clr_err = 1'b1;
      push(6'h3E);
      clr_err = 1'b0;
      chk("clr_vs_set", 32'(overflow), 32'd1);
      clr_err = 1'b1;
      step();
      clr_err = 1'b0;
      chk("clr_ovf2", 32'(overflow), 32'd0);

      // Simultaneous push/pop while full
      chk("simul_head", 32'(dout), 32'h01);
      wE  = 1'b1;
      din = 6'h2A;
      rE  = 1'b1;
      step();
      wE  = 1'b0;
      rE  = 1'b0;
      chk("simul_count", 32'(count), 32'd8);
      chk("simul_out", 32'(dout), 32'h02);
      chk("simul_ovf", 32'(overflow), 32'd0);
      for (int i = 2; i <= 8; i++) pop_chk("drain_pop", 6'(i));
      pop_chk("drain_2a", 6'h2A);
      chk("drain_empty", 32'(empty), 32'd1);
      chk("drain_count", 32'(count), 32'd0);

      // Pop when empty
      rE = 1'b1;
      step();
      rE = 1'b0;
      chk("udf_set", 32'(underflow), 32'd1);
      chk("udf_count", 32'(count), 32'd0);
      clr_err = 1'b1;
      step();
      clr_err = 1'b0;
      chk("udf_clr", 32'(underflow), 32'd0);
      wE  = 1'b1;
      din = 6'h07;
      rE  = 1'b1;
      step();
      wE  = 1'b0;
      rE  = 1'b0;
      chk("udf_push_count", 32'(count), 32'd1);
      chk("udf_push_out", 32'(dout), 32'h07);
      chk("udf_push_flag", 32'(underflow), 32'd1);
      pop_chk("udf_pop", 6'h07);
      clr_err = 1'b1;
      step();
      clr_err = 1'b0;

      // Wrap-around: 4 rounds of push 5 / pop 5
      d = 6'h20;
      for (int r = 0; r < 4; r++) begin
         for (int k = 0; k < 5; k++) push(d + 6'(k));
         chk("wrap_count", 32'(count), 32'd5);
         for (int k = 0; k < 5; k++) pop_chk("wrap_pop", d + 6'(k));
         chk("wrap_empty", 32'(empty), 32'd1);
         d = d + 6'd5;
      end
      chk("wrap_no_err", 32'({overflow, underflow}), 32'd0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
